// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: shadow-captures BCD digits, commits them at frame wrap.
// Outputs registered one cycle behind the scan index; no backpressure, load is accepted every cycle.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam int   DIV_W   = $clog2(REFRESH_DIV);
    localparam logic SEG_INV = (ACTIVE_LOW_SEG != 0);
    localparam logic AN_INV  = (ACTIVE_LOW_AN != 0);

    localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b1000000;
        endcase
        return p;
    endfunction

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dp_disp_q, dp_disp_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    slot_end;
    logic                    wrap;
    logic                    lead;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_dig;
    logic                    cur_blank;
    logic                    cur_dp;

    // Scan divider, frame commit and shadow capture.
    always_comb begin
        slot_end = (div_q == DIV_W'(REFRESH_DIV - 1));
        wrap     = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

        div_d = slot_end ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        frame_done_d = wrap;

        // Commit uses the shadow as it stood before this edge, so a load
        // landing on the wrap edge waits for the following frame.
        disp_d    = disp_q;
        dp_disp_d = dp_disp_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            disp_d    = shadow_q;
            dp_disp_d = dp_shadow_q;
            pending_d = 1'b0;
        end

        shadow_d    = shadow_q;
        dp_shadow_d = dp_shadow_q;
        if (load) begin
            shadow_d    = digits_in;
            dp_shadow_d = dp_in;
            pending_d   = 1'b1;
        end
    end

    // Leading-zero blanking from the most significant digit down; digit 0 always shows.
    always_comb begin
        lead      = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead         = lead & (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = blank_lz & lead;
        end
    end

    always_comb begin
        cur_dig   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig   = disp_q[4*i +: 4];
                cur_blank = blank_vec[i];
                cur_dp    = dp_disp_q[i];
                onehot[i] = 1'b1;
            end
        end

        an_d  = onehot ^ AN_OFF;
        seg_d = (cur_blank ? 7'b0000000 : seg_decode(cur_dig)) ^ SEG_OFF;
        dp_d  = (cur_dp & ~cur_blank) ^ SEG_INV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            dp_shadow_q  <= '0;
            disp_q       <= '0;
            dp_disp_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= SEG_INV;
            an_q         <= AN_OFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dp_shadow_q  <= dp_shadow_d;
            disp_q       <= disp_d;
            dp_disp_q    <= dp_disp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots, active-low outputs.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SDSH = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(4),
        .ACTIVE_LOW_SEG(1),
        .ACTIVE_LOW_AN(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ticks until frame_done is seen; returns the tick count (41 if it never came).
    task automatic wait_frame(output int n);
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Starts just after a frame_done sample; checks one full 16-cycle frame.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpx);
        logic [3:0] one;
        logic [6:0] es;
        logic       fd_exp;
        int         slot;
        for (int k = 1; k <= 16; k++) begin
            tick();
            slot   = (k - 1) / 4;
            one    = 4'b0001 << slot;
            fd_exp = (k == 16);
            case (slot)
                0:       es = s0;
                1:       es = s1;
                2:       es = s2;
                default: es = s3;
            endcase
            check($sformatf("%s_an%0d", tag, k), {28'b0, an}, {28'b0, ~one});
            check($sformatf("%s_seg%0d", tag, k), {25'b0, seg}, {25'b0, es});
            check($sformatf("%s_dp%0d", tag, k), {31'b0, dp}, {31'b0, dpx[slot]});
            check($sformatf("%s_fd%0d", tag, k), {31'b0, frame_done}, {31'b0, fd_exp});
            check($sformatf("%s_onehot%0d", tag, k), $countones(~an), 1);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        repeat (3) tick();
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_seg", {25'b0, seg}, {25'b0, SOFF});
        check("rst_dp", {31'b0, dp}, 32'h1);
        check("rst_fd", {31'b0, frame_done}, 32'h0);

        // 1. load 1259 right out of reset, dp on digit 0
        rst       = 1'b0;
        load      = 1'b1;
        digits_in = 16'h1259;
        dp_in     = 4'b0001;
        tick();
        load = 1'b0;
        check("t1_first_an", {28'b0, an}, 32'hE);
        check("t1_first_seg", {25'b0, seg}, {25'b0, S0});
        wait_frame(n);
        check("t1_wrap_lat", n, 15);
        check_frame("t1", S9, S5, S2, S1, 4'b1110);

        // 2. free-running frame period
        wait_frame(n);
        check("t2_period_a", n, 16);
        wait_frame(n);
        check("t2_period_b", n, 16);

        // 3. mid-frame load with blanking: old digits hold until the wrap
        repeat (5) tick();
        load      = 1'b1;
        digits_in = 16'h0042;
        dp_in     = 4'b0110;
        blank_lz  = 1'b1;
        tick();
        load = 1'b0;
        check("t3_hold_an", {28'b0, an}, 32'hD);
        check("t3_hold_seg", {25'b0, seg}, {25'b0, S5});
        wait_frame(n);
        check("t3_wrap_lat", n, 10);
        check_frame("t3", S2, S4, SOFF, SOFF, 4'b1101);

        // 4. non-decimal code shows a dash, no blanking
        load      = 1'b1;
        digits_in = 16'h000A;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
        tick();
        load = 1'b0;
        wait_frame(n);
        check("t4_wrap_lat", n, 15);
        check_frame("t4", SDSH, S0, S0, S0, 4'b1111);

        // 5. load on the wrap edge commits the older shadow first
        repeat (3) tick();
        load      = 1'b1;
        digits_in = 16'h3333;
        tick();
        load = 1'b0;
        repeat (11) tick();
        load      = 1'b1;
        digits_in = 16'h8888;
        tick();
        load = 1'b0;
        check("t5_wrap_edge", {31'b0, frame_done}, 32'h1);
        check_frame("t5a", S3, S3, S3, S3, 4'b1111);
        check_frame("t5b", S8, S8, S8, S8, 4'b1111);

        // 6. reset mid-slot discards pending data
        load      = 1'b1;
        digits_in = 16'h4444;
        blank_lz  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_an", {28'b0, an}, 32'hF);
        check("t6_rst_seg", {25'b0, seg}, {25'b0, SOFF});
        check("t6_rst_dp", {31'b0, dp}, 32'h1);
        check("t6_rst_fd", {31'b0, frame_done}, 32'h0);
        rst = 1'b0;
        tick();
        check("t6_rel_an", {28'b0, an}, 32'hE);
        check("t6_rel_seg", {25'b0, seg}, {25'b0, S0});
        wait_frame(n);
        check("t6_wrap_lat", n, 15);
        check_frame("t6", S0, SOFF, SOFF, SOFF, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
